ftdi_tx_ctrl: RTL and testbench
===============================

// Module: ftdi_tx_ctrl
// PURPOSE
//  Write-side companion to the FT245-style receive controller. Buffers bytes from the
//  core in a local FIFO and strobes them into the FTDI TX FIFO via txe/wr.
//  Shares the bidirectional dq bus with the receive side through a bus_busy/bus_req
//  arbitration pair; the top level muxes dq_out/dq_oe onto the dq pad.
// PARAMETERS
//  DEPTH        16  local FIFO depth in bytes, power of 2, >=2
//  AW           4   log2(DEPTH)
//  SETUP_CYCLES 1   clocks dq is driven before the wr falling edge, 1..15
//  WR_CYCLES    2   clocks wr is held low, 1..15
// PORTS
//  clk       in   1    system clock
//  n_rst     in   1    async reset, active low
//  tx_data   in   8    byte from core
//  tx_valid  in   1    tx_data valid; byte accepted when tx_valid & tx_ready
//  tx_ready  out  1    local FIFO not full
//  txe       in   1    FTDI TX FIFO has space when low; async, 2-FF synchronised internally
//  bus_busy  in   1    receive side owns dq (its oe low); tx must not start
//  bus_req   out  1    high while tx owns dq (SETUP..HOLD); receive side must not start
//  dq_out    out  8    byte driven to the dq pad
//  dq_oe     out  1    1 = drive dq_out onto dq
//  wr        out  1    FTDI write strobe, active low; FTDI latches dq on the wr rising edge
//  level     out  AW+1 local FIFO occupancy, 0..DEPTH
//  overflow  out  1    sticky: push attempted while full; cleared only by reset
// BEHAVIOUR
//  Reset: FSM=IDLE, wr=1, dq_oe=0, dq_out=0, bus_req=0, level=0, tx_ready=1, overflow=0,
//   FIFO pointers=0, txe synchroniser=1 (FTDI treated as full).
//  FIFO: rd/wr pointers AW+1 bits; wrap-around with MSB compare; full = DEPTH entries.
//   Push and pop in the same cycle are both honoured, so level is unchanged.
//   Push while full: data dropped, overflow<=1, level unchanged.
//   tx_ready is registered-equivalent: it depends only on level, never on tx_valid.
//  FSM (single-cycle state register; cnt is a 4-bit down-counter):
//   IDLE  : when level!=0 & txe_s==0 & bus_busy==0 -> SETUP; dq_out<=FIFO head, dq_oe<=1,
//           bus_req<=1, cnt<=SETUP_CYCLES-1.
//   SETUP : wr=1; cnt==0 -> STROBE, wr<=0, cnt<=WR_CYCLES-1; else cnt--.
//   STROBE: wr=0; cnt==0 -> HOLD, wr<=1; else cnt--.
//   HOLD  : wr=1, dq still driven for exactly 1 clk; pop FIFO; -> IDLE, dq_oe<=0, bus_req<=0.
//   default/illegal -> IDLE with outputs at reset values.
//  Byte period = SETUP_CYCLES+WR_CYCLES+1 clocks. IDLE lasts at least 1 clk between bytes,
//   so txe_s can be re-sampled after FTDI updates txe.
//  txe rising during SETUP/STROBE does not abort the byte: FTDI accepts the current write.
//  bus_busy is sampled only in IDLE. If bus_busy and a start condition arrive in the same
//   cycle, bus_busy wins and the receive side has priority.
//  dq_out is stable throughout SETUP..HOLD; wr never falls while dq_oe==0.
//  Async reset mid-byte: wr returns to 1 and dq_oe to 0 immediately; FIFO contents lost.
// CONFIGURATION
//  FTDI_TX_SIWU_EN defined: adds output siwu (1 bit, active low, reset 1). siwu is pulsed
//   low for 1 clk in the IDLE cycle after the HOLD that empties the local FIFO, which makes
//   the FTDI flush a short packet to the USB host. No pulse occurs while level!=0.
//  Not defined: no siwu port. The FTDI flushes on its own latency timer.
// TESTING
//  1. Reset, txe=0, bus_busy=0, push 0xA5 -> dq_oe=1 next clk; wr low 2 clks after 1 setup clk;
//     dq=0xA5 at wr rise; level returns to 0; 4-clk byte period.
//  2. Push 16 bytes 0x00..0x0F with txe=1 -> tx_ready=0, level=16; push 0xFF -> overflow=1;
//     release txe=0 -> 0x00..0x0F appear on dq in order; 0xFF is never written.
//  3. Push and pop in the same cycle at level=5 -> level stays 5; pointers wrap after 40 bytes,
//     data order preserved.
//  4. bus_busy=1 with data queued -> wr=1, dq_oe=0, bus_req=0 indefinitely; drop bus_busy ->
//     SETUP within 1 clk after the txe synchroniser settles.
//  5. Assert n_rst=0 during STROBE -> wr=1 and dq_oe=0 asynchronously; level=0 after release.
//  6. FTDI_TX_SIWU_EN: send 3 bytes -> exactly one siwu low pulse, 1 clk after the third HOLD.

Source files
------------

// File: rtl/ftdi_tx_ctrl.sv
// FT245-style write controller: local byte FIFO drained into the FTDI TX FIFO via txe/wr.
// Optional macro FTDI_TX_SIWU_EN adds the o_siwu flush pulse after the FIFO runs dry.
module ftdi_tx_ctrl #(
    parameter int DEPTH        = 16,
    parameter int AW           = 4,
    parameter int SETUP_CYCLES = 1,
    parameter int WR_CYCLES    = 2
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic [7:0]    i_tx_data,
    input  logic          i_tx_valid,
    output logic          o_tx_ready,
    input  logic          i_txe,
    input  logic          i_bus_busy,
    output logic          o_bus_req,
    output logic [7:0]    o_dq_out,
    output logic          o_dq_oe,
    output logic          o_wr,
    output logic [AW:0]   o_level,
    output logic          o_overflow
`ifdef FTDI_TX_SIWU_EN
    ,
    output logic          o_siwu
`endif
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_STROBE = 2'd2,
        S_HOLD   = 2'd3
    } state_t;

    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
    localparam logic [3:0]  SETUP_L = 4'(SETUP_CYCLES - 1);
    localparam logic [3:0]  WR_L    = 4'(WR_CYCLES - 1);

    // ---------------- local FIFO ----------------
    logic [7:0]  r_mem [DEPTH];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic        r_overflow;
    logic [AW:0] w_level;
    logic        w_full;
    logic        w_push;
    logic        w_pop;
    logic [7:0]  w_head;

    assign w_level = r_wr_ptr - r_rd_ptr;
    assign w_full  = (w_level == DEPTH_L);
    assign w_push  = i_tx_valid & ~w_full;
    assign w_head  = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr[AW-1:0]] <= i_tx_data;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            if (i_tx_valid && w_full)
                r_overflow <= 1'b1;
        end
    end

    // txe is asynchronous to clk; reset value 1 treats the FTDI as full
    logic r_txe_meta;
    logic r_txe_s;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_txe_meta <= 1'b1;
            r_txe_s    <= 1'b1;
        end else begin
            r_txe_meta <= i_txe;
            r_txe_s    <= r_txe_meta;
        end
    end

    // ---------------- write FSM ----------------
    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_nxt;
    logic       r_wr;
    logic       r_dq_oe;
    logic       r_bus_req;
    logic [7:0] r_dq_out;
    logic       w_wr_nxt;
    logic       w_dq_oe_nxt;
    logic       w_bus_req_nxt;
    logic [7:0] w_dq_out_nxt;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_wr      <= 1'b1;
            r_dq_oe   <= 1'b0;
            r_bus_req <= 1'b0;
            r_dq_out  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_wr      <= w_wr_nxt;
            r_dq_oe   <= w_dq_oe_nxt;
            r_bus_req <= w_bus_req_nxt;
            r_dq_out  <= w_dq_out_nxt;
        end
    end

    // bus_busy only gates the start decision, so the receive side wins ties
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if ((w_level != '0) && !r_txe_s && !i_bus_busy) begin
                    w_state_nxt = S_SETUP;
                    w_cnt_nxt   = SETUP_L;
                end
            end
            S_SETUP: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = S_STROBE;
                    w_cnt_nxt   = WR_L;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            S_STROBE: begin
                if (r_cnt == 4'd0)
                    w_state_nxt = S_HOLD;
                else
                    w_cnt_nxt = r_cnt - 4'd1;
            end
            S_HOLD: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so wr/dq_oe cannot glitch
    always_comb begin
        w_wr_nxt      = (w_state_nxt != S_STROBE);
        w_dq_oe_nxt   = (w_state_nxt != S_IDLE);
        w_bus_req_nxt = (w_state_nxt != S_IDLE);
        w_dq_out_nxt  = r_dq_out;
        w_pop         = 1'b0;
        case (r_state)
            S_IDLE:   if (w_state_nxt == S_SETUP) w_dq_out_nxt = w_head;
            S_SETUP:  ;
            S_STROBE: ;
            S_HOLD:   w_pop = 1'b1;
            default:  w_dq_out_nxt = '0;
        endcase
    end

`ifdef FTDI_TX_SIWU_EN
    // Low for the IDLE cycle after the HOLD that leaves the FIFO empty
    logic r_siwu;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            r_siwu <= 1'b1;
        else
            r_siwu <= !((r_state == S_HOLD) && (w_level == (AW+1)'(1)) && !w_push);
    end

    assign o_siwu = r_siwu;
`endif

    assign o_tx_ready = ~w_full;
    assign o_level    = w_level;
    assign o_overflow = r_overflow;
    assign o_wr       = r_wr;
    assign o_dq_oe    = r_dq_oe;
    assign o_bus_req  = r_bus_req;
    assign o_dq_out   = r_dq_out;

endmodule

// File: tb/tb_ftdi_tx_ctrl.sv
// Scoreboard bench for ftdi_tx_ctrl: bytes queued at push, compared at every wr rising edge.
// Build with FTDI_TX_SIWU_EN defined to also exercise the siwu flush pulse.
module tb_ftdi_tx_ctrl;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          n_rst = 1'b0;
    logic [7:0]    tx_data = 8'h00;
    logic          tx_valid = 1'b0;
    logic          txe = 1'b0;
    logic          bus_busy = 1'b0;
    logic          tx_ready;
    logic          bus_req;
    logic [7:0]    dq_out;
    logic          dq_oe;
    logic          wr;
    logic [AW:0]   level;
    logic          overflow;
`ifdef FTDI_TX_SIWU_EN
    logic          siwu;
`endif

    int         checks = 0;
    int         failures = 0;
    int         wr_count = 0;
    logic [7:0] q[$];
    bit         prev_wr = 1'b1;

    ftdi_tx_ctrl #(.DEPTH(DEPTH), .AW(AW), .SETUP_CYCLES(1), .WR_CYCLES(2)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .i_tx_data  (tx_data),
        .i_tx_valid (tx_valid),
        .o_tx_ready (tx_ready),
        .i_txe      (txe),
        .i_bus_busy (bus_busy),
        .o_bus_req  (bus_req),
        .o_dq_out   (dq_out),
        .o_dq_oe    (dq_oe),
        .o_wr       (wr),
        .o_level    (level),
        .o_overflow (overflow)
`ifdef FTDI_TX_SIWU_EN
        ,
        .o_siwu     (siwu)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Scoreboard: every wr rising edge must carry the oldest queued byte
    always @(negedge clk) begin
        if (!n_rst) begin
            prev_wr = 1'b1;
        end else begin
            if (wr === 1'b0) begin
                checks++;
                if (dq_oe !== 1'b1) begin
                    failures++;
                    $display("FAIL wr_low_oe: dq_oe=%0b required 1 while wr low", dq_oe);
                end
            end
            if (prev_wr == 1'b0 && wr === 1'b1) begin
                wr_count++;
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_write: dq=%0h with nothing queued", dq_out);
                end else begin
                    logic [7:0] e;
                    e = q.pop_front();
                    if (dq_out !== e) begin
                        failures++;
                        $display("FAIL write_data: dq=%0h required %0h", dq_out, e);
                    end
                end
            end
            prev_wr = wr;
        end
    end

    task automatic push(input logic [7:0] d, input bit accept);
        tx_data  = d;
        tx_valid = 1'b1;
        if (accept) q.push_back(d);
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic wait_idle(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (q.size() == 0 && level == '0 && dq_oe == 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        n_rst = 1'b0; txe = 1'b0; bus_busy = 1'b0; tx_valid = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({wr, dq_oe, bus_req, dq_out} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
            failures++;
            $display("FAIL reset_bus: wr/oe/req/dq=%0b%0b%0b/%0h required 100/00", wr, dq_oe, bus_req, dq_out);
        end
        checks++;
        if ({level, tx_ready, overflow} !== {5'd0, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL reset_fifo: level=%0d ready=%0b ovf=%0b required 0 1 0", level, tx_ready, overflow);
        end
`ifdef FTDI_TX_SIWU_EN
        checks++;
        if (siwu !== 1'b1) begin
            failures++;
            $display("FAIL reset_siwu: siwu=%0b required 1", siwu);
        end
`endif
        n_rst = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_single();
        bit [5:0] exp_oe = 6'b011110;
        bit [5:0] exp_wr = 6'b110011;
        int       c0 = wr_count;
        push(8'hA5, 1'b1);
        for (int k = 0; k < 6; k++) begin
            if (k > 0) @(negedge clk);
            checks++;
            if (dq_oe !== exp_oe[k] || wr !== exp_wr[k] || bus_req !== exp_oe[k]) begin
                failures++;
                $display("FAIL single_seq[%0d]: oe/wr/req=%0b%0b%0b required %0b%0b%0b",
                         k, dq_oe, wr, bus_req, exp_oe[k], exp_wr[k], exp_oe[k]);
            end
        end
        checks++;
        if (level !== 5'd0 || wr_count - c0 != 1) begin
            failures++;
            $display("FAIL single_end: level=%0d writes=%0d required 0 1", level, wr_count - c0);
        end
    endtask

    task automatic test_overflow();
        bit ok;
        int c0;
        txe = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 16; i++) push(8'(i), 1'b1);
        checks++;
        if (level !== 5'd16 || tx_ready !== 1'b0) begin
            failures++;
            $display("FAIL full: level=%0d ready=%0b required 16 0", level, tx_ready);
        end
        push(8'hFF, 1'b0);
        checks++;
        if (overflow !== 1'b1 || level !== 5'd16) begin
            failures++;
            $display("FAIL overflow: ovf=%0b level=%0d required 1 16", overflow, level);
        end
        c0 = wr_count;
        txe = 1'b0;
        wait_idle(400, ok);
        checks++;
        if (!ok || wr_count - c0 != 16) begin
            failures++;
            $display("FAIL drain16: done=%0b writes=%0d required 1 16", ok, wr_count - c0);
        end
        checks++;
        if (overflow !== 1'b1) begin
            failures++;
            $display("FAIL overflow_sticky: ovf=%0b required 1", overflow);
        end
    endtask

    task automatic test_same_cycle();
        bit ok;
        bit found = 1'b0;
        bit p = 1'b1;
        txe = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 5; i++) push(8'h50 + 8'(i), 1'b1);
        txe = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (p == 1'b0 && wr === 1'b1 && dq_oe === 1'b1) begin
                found = 1'b1;
                break;
            end
            p = wr;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL hold_seen: found=0 required 1");
        end
        push(8'h77, 1'b1);
        checks++;
        if (level !== 5'd5) begin
            failures++;
            $display("FAIL push_pop: level=%0d required 5", level);
        end
        wait_idle(200, ok);
        for (int i = 0; i < 40; i++) begin
            push(8'h80 + 8'(i), 1'b1);
            repeat (5) @(negedge clk);
        end
        wait_idle(200, ok);
        checks++;
        if (!ok || q.size() != 0) begin
            failures++;
            $display("FAIL wrap40: done=%0b left=%0d required 1 0", ok, q.size());
        end
    endtask

    task automatic test_bus_busy();
        bit ok;
        bit bad = 1'b0;
        bus_busy = 1'b1;
        for (int i = 0; i < 3; i++) push(8'hC0 + 8'(i), 1'b1);
        repeat (20) begin
            @(negedge clk);
            if (wr !== 1'b1 || dq_oe !== 1'b0 || bus_req !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad || level !== 5'd3) begin
            failures++;
            $display("FAIL busy_block: bad=%0b level=%0d required 0 3", bad, level);
        end
        bus_busy = 1'b0;
        @(negedge clk);
        checks++;
        if (dq_oe !== 1'b1 || bus_req !== 1'b1) begin
            failures++;
            $display("FAIL busy_release: oe=%0b req=%0b required 1 1", dq_oe, bus_req);
        end
        wait_idle(100, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL busy_drain: done=0 required 1");
        end
    endtask

    task automatic test_reset_mid();
        bit found = 1'b0;
        int c0;
        push(8'hD0, 1'b1);
        push(8'hD1, 1'b1);
        for (int i = 0; i < 30; i++) begin
            if (wr === 1'b0) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        #2 n_rst = 1'b0;
        #1;
        checks++;
        if (!found || wr !== 1'b1 || dq_oe !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: strobe=%0b wr=%0b oe=%0b required 1 1 0", found, wr, dq_oe);
        end
        q.delete();
        @(negedge clk);
        @(negedge clk);
        n_rst = 1'b1;
        c0 = wr_count;
        repeat (10) @(negedge clk);
        checks++;
        if (level !== 5'd0 || tx_ready !== 1'b1 || overflow !== 1'b0 || wr_count != c0) begin
            failures++;
            $display("FAIL after_reset: level=%0d ready=%0b ovf=%0b writes=%0d required 0 1 0 0",
                     level, tx_ready, overflow, wr_count - c0);
        end
    endtask

`ifdef FTDI_TX_SIWU_EN
    task automatic test_siwu();
        int lows = 0;
        bit lvl_bad = 1'b0;
        for (int i = 0; i < 3; i++) push(8'hE0 + 8'(i), 1'b1);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (siwu === 1'b0) begin
                lows++;
                if (level !== 5'd0) lvl_bad = 1'b1;
            end
        end
        checks++;
        if (lows != 1 || lvl_bad) begin
            failures++;
            $display("FAIL siwu_pulse: lows=%0d lvl_bad=%0b required 1 0", lows, lvl_bad);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_same_cycle();
        test_bus_busy();
        test_reset_mid();
`ifdef FTDI_TX_SIWU_EN
        test_siwu();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
